sobol_uniform_gen: RTL and testbench
====================================

// Module: sobol_uniform_gen
// PURPOSE
// - Gray-code (Antonov-Saleev) Sobol low-discrepancy generator; source of the uniform u stream.
// - Feeds the inverse-CDF normal stage: emits DIMS interleaved samples per point as Qx.QFRAC values in (0,1).
// - Point index 0 (u=0, ln(0) undefined downstream) is never emitted.
// - Direction numbers are loaded by the host before each run; runs are start/done controlled.
// PARAMETERS
// WIDTH     32  output word width (signed container, always non-negative)
// QFRAC     21  fractional bits of u_out
// DIMS      4   number of Sobol dimensions, interleaved per point
// M_BITS    32  direction-number / state width; also point-index width
// PORTS
// clk         in   1                   clock
// rst_n       in   1                   synchronous reset, active-low
// dv_we       in   1                   direction-number write strobe
// dv_dim      in   $clog2(DIMS)        direction-number dimension
// dv_bit      in   $clog2(M_BITS)      direction-number index k
// dv_data     in   M_BITS              V[dim][k], MSB-aligned binary fraction
// start       in   1                   start-run pulse
// n_points    in   M_BITS              points per run (>=1), sampled at start
// busy        out  1                   high from accepted start until done
// done        out  1                   1-cycle pulse after last sample accepted
// valid_out   out  1                   u_out/dim_out/idx_out valid
// ready_in    in   1                   downstream accept
// u_out       out  WIDTH               uniform sample, Q(WIDTH-QFRAC).QFRAC, in (0,1)
// dim_out     out  $clog2(DIMS)        dimension of u_out
// idx_out     out  M_BITS              point index of u_out (1-based)
// BEHAVIOUR
// - Reset: busy=0, done=0, valid_out=0, u_out=0, dim_out=0, idx_out=0.
//   State -> IDLE; x[*] cleared. Direction-number RAM NOT reset; contents retained.
// - FSM IDLE -> RUN -> DRAIN -> IDLE.
// - IDLE:
//   - dv_we writes V[dv_dim][dv_bit]; dv_we ignored in RUN/DRAIN.
//   - start with n_points!=0: latch N, x[*]=0, idx=1, d=0, busy=1 -> RUN.
//   - start with n_points==0: ignored; no done.
//   - start ignored while busy. If dv_we and start coincide in IDLE: write completes, run uses new value.
// - RUN: advance when (!valid_out || ready_in):
//   - c = position of lowest zero bit of (idx-1).
//   - xn = x[d] ^ V[d][c]; x[d]<=xn.
//   - u_out <= {0, xn[M_BITS-1 -: QFRAC]}; if the truncated field is 0, u_out<=1 LSB (clamp).
//   - dim_out<=d, idx_out<=idx, valid_out<=1.
//   - d++; on d==DIMS-1 wrap d=0 and idx++.
//   - When loading idx==N, d==DIMS-1 -> DRAIN.
// - DRAIN: on valid_out&&ready_in -> valid_out=0, done=1 for one cycle, busy=0, IDLE.
// - Handshake: registered 1-deep output.
//   - u_out/dim_out/idx_out held stable while valid_out&&!ready_in.
//   - Throughput 1 sample/cycle with ready_in=1; no bubbles between points.
// - Latency: start sampled at edge k; first valid_out high after edge k+1.
// - Sign bit and integer bits of u_out always 0; u_out never 0 and never >=1.0.
// - Index wrap: N<=2^M_BITS-1, so c<M_BITS always; no wrap handling needed.
// - Reset mid-run: immediate return to reset state; any pending sample is discarded, no done.
// TESTING
// - Van der Corput: V[0][k]=1<<(31-k), N=4, ready=1.
//   -> u_out 0x100000,0x180000,0x080000,0x0C0000; idx 1..4; done 1 cycle after last.
// - DIMS=2, dim1 loaded same as dim0, N=2.
//   -> order (d0,i1),(d1,i1),(d0,i2),(d1,i2); values 0x100000,0x100000,0x180000,0x180000.
// - Backpressure: ready_in low 5 cycles mid-run.
//   -> outputs frozen; no sample lost/duplicated; sequence identical to ready=1 run.
// - Clamp: V[0][0]=0x00000400 (below 1 LSB), N=1 -> u_out=0x000001.
// - Control: start while busy ignored; n_points=0 start ignored; dv_we during RUN leaves RAM unchanged
//   (verify via next run).
// - rst_n low at sample 3 of N=8 -> valid_out=0 next cycle, busy=0, no done.
//   A rerun gives an identical first 8 samples (RAM retained).

Source files
------------

// File: rtl/sobol_uniform_gen.sv
// Gray-code (Antonov-Saleev) Sobol generator emitting DIMS interleaved uniform samples per point.
// Output is a registered 1-deep valid/ready stage; direction numbers live in a host-loaded RAM.
module sobol_uniform_gen #(
  parameter int WIDTH  = 32,
  parameter int QFRAC  = 21,
  parameter int DIMS   = 4,
  parameter int M_BITS = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dv_we,
  input  logic [$clog2(DIMS)-1:0]   dv_dim,
  input  logic [$clog2(M_BITS)-1:0] dv_bit,
  input  logic [M_BITS-1:0]         dv_data,
  input  logic                      start,
  input  logic [M_BITS-1:0]         n_points,
  output logic                      busy,
  output logic                      done,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic [WIDTH-1:0]          u_out,
  output logic [$clog2(DIMS)-1:0]   dim_out,
  output logic [M_BITS-1:0]         idx_out
);
  localparam int DW = $clog2(DIMS);
  localparam int CW = $clog2(M_BITS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                       state;
  logic [M_BITS-1:0]            vram [DIMS][M_BITS];
  logic [DIMS-1:0][M_BITS-1:0]  x;
  logic [M_BITS-1:0]            n_lat, idx, idx_m1, xn;
  logic [DW-1:0]                d;
  logic [CW-1:0]                c;
  logic [QFRAC-1:0]             frac;
  logic                         adv, last;

  // Direction RAM has no reset so the host's table survives a reset.
  always_ff @(posedge clk)
    if (rst_n && state == IDLE && dv_we) vram[dv_dim][dv_bit] <= dv_data;

  always_comb begin
    idx_m1 = idx - M_BITS'(1);
    c = '0;
    for (int i = M_BITS-1; i >= 0; i--)
      if (!idx_m1[i]) c = CW'(i);
    xn   = x[d] ^ vram[d][c];
    frac = xn[M_BITS-1 -: QFRAC];
    adv  = !valid_out || ready_in;
    last = (idx == n_lat) && (d == DW'(DIMS-1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid_out <= 1'b0;
      u_out     <= '0;
      dim_out   <= '0;
      idx_out   <= '0;
      x         <= '0;
      idx       <= '0;
      d         <= '0;
      n_lat     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start && n_points != '0) begin
            n_lat <= n_points;
            x     <= '0;
            idx   <= M_BITS'(1);
            d     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        RUN:
          if (adv) begin
            x[d] <= xn;
            // A zero fraction would feed ln(0) downstream; clamp to one LSB.
            u_out     <= (frac == '0) ? WIDTH'(1) : WIDTH'(frac);
            dim_out   <= d;
            idx_out   <= idx;
            valid_out <= 1'b1;
            if (d == DW'(DIMS-1)) begin
              d   <= '0;
              idx <= idx + M_BITS'(1);
            end else begin
              d <= d + DW'(1);
            end
            if (last) state <= DRAIN;
          end
        DRAIN:
          if (valid_out && ready_in) begin
            valid_out <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sobol_uniform_gen.sv
// Directed bench for sobol_uniform_gen: a DIMS=4 instance for most scenarios and a DIMS=2
// instance for the interleave-order case.
module tb_sobol_uniform_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, we_a = 1'b0, we_b = 1'b0, ready_in = 1'b1;
  logic [1:0]  dv_dim = '0;
  logic [4:0]  dv_bit = '0;
  logic [31:0] dv_data = '0, n_points = '0;

  logic        busy_a, done_a, valid_a, busy_b, done_b, valid_b;
  logic [31:0] u_a, idx_a, u_b, idx_b;
  logic [1:0]  dim_a;
  logic [0:0]  dim_b;

  always #5 clk = ~clk;

  sobol_uniform_gen #(.DIMS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .dv_we(we_a), .dv_dim(dv_dim), .dv_bit(dv_bit),
    .dv_data(dv_data), .start(start_a), .n_points(n_points), .busy(busy_a),
    .done(done_a), .valid_out(valid_a), .ready_in(ready_in), .u_out(u_a),
    .dim_out(dim_a), .idx_out(idx_a));

  sobol_uniform_gen #(.DIMS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .dv_we(we_b), .dv_dim(dv_dim[0]), .dv_bit(dv_bit),
    .dv_data(dv_data), .start(start_b), .n_points(n_points), .busy(busy_b),
    .done(done_b), .valid_out(valid_b), .ready_in(ready_in), .u_out(u_b),
    .dim_out(dim_b), .idx_out(idx_b));

  int checks = 0, passes = 0;

  logic        sel = 1'b0;
  logic        o_valid, o_done, o_busy;
  logic [31:0] o_u, o_idx;
  logic [1:0]  o_dim;
  always_comb begin
    o_valid = sel ? valid_b : valid_a;
    o_done  = sel ? done_b  : done_a;
    o_busy  = sel ? busy_b  : busy_a;
    o_u     = sel ? u_b     : u_a;
    o_idx   = sel ? idx_b   : idx_a;
    o_dim   = sel ? {1'b0, dim_b} : dim_a;
  end

  logic [31:0] cap_u [64], cap_idx [64], ref_u [32], ref_idx [32];
  logic [1:0]  cap_dim [64], ref_dim [32];
  int          cap_n, first_vld, last_acc, done_cyc, done_cnt;
  bit          timed_out, frozen_bad, busy0;

  function automatic logic [31:0] vfor(input int dim, input int k);
    logic [31:0] one;
    one = 32'h8000_0000;
    case (dim)
      0: return one >> k;
      1: return one >> (k + 1);
      2: return one >> (k + 2);
      default:
        case (k)
          0: return 32'h8000_0000;
          1: return 32'hC000_0000;
          2: return 32'hA000_0000;
          3: return 32'hF000_0000;
          default: return one >> k;
        endcase
    endcase
  endfunction

  task automatic wr(input bit s, input int dim, input int k, input logic [31:0] data);
    dv_dim = dim[1:0]; dv_bit = k[4:0]; dv_data = data;
    if (s) we_b = 1'b1; else we_a = 1'b1;
    @(posedge clk); #1;
    we_a = 1'b0; we_b = 1'b0;
  endtask

  // Launches a run and records every accepted sample; optional stall and mid-run poke.
  task automatic run(input bit s, input logic [31:0] n, input int stall_at, input int stall_len,
                     input int poke_cyc);
    int stalls;
    logic [31:0] hu, hi;
    logic [1:0]  hd;
    sel = s; cap_n = 0; first_vld = -1; last_acc = -1; done_cyc = -1; done_cnt = 0;
    timed_out = 1'b0; frozen_bad = 1'b0; stalls = stall_len; hu = '0; hi = '0; hd = '0;
    n_points = n; ready_in = 1'b1;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      start_a = 1'b0; we_a = 1'b0;
      if (cyc == 0) busy0 = o_busy;
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      if (o_valid && first_vld < 0) first_vld = cyc;
      if (cyc == poke_cyc) begin
        start_a = 1'b1; n_points = 32'd8;
        we_a = 1'b1; dv_dim = 2'd0; dv_bit = 5'd0; dv_data = 32'h0;
      end
      if (o_valid && cap_n == stall_at && stall_len > 0 && stalls < stall_len)
        if (o_u !== hu || o_dim !== hd || o_idx !== hi) frozen_bad = 1'b1;
      if (o_valid && cap_n == stall_at && stalls > 0) begin
        if (stalls == stall_len) begin hu = o_u; hd = o_dim; hi = o_idx; end
        ready_in = 1'b0;
        stalls--;
      end else begin
        ready_in = 1'b1;
      end
      if (o_valid && ready_in && cap_n < 64) begin
        cap_u[cap_n] = o_u; cap_dim[cap_n] = o_dim; cap_idx[cap_n] = o_idx;
        cap_n++;
        last_acc = cyc;
      end
      if (cyc == 399) timed_out = 1'b1;
    end
    ready_in = 1'b1; start_a = 1'b0; we_a = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else passes++;
    checks++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b want 0", done_a); else passes++;
    checks++; if (valid_a !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_a); else passes++;
    checks++; if (u_a !== 32'h0) $display("FAIL reset_u: got %h want 0", u_a); else passes++;
    checks++; if (dim_a !== 2'd0) $display("FAIL reset_dim: got %0d want 0", dim_a); else passes++;
    checks++; if (idx_a !== 32'h0) $display("FAIL reset_idx: got %0d want 0", idx_a); else passes++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vdc;
    logic [31:0] exp_u [16] = '{
      32'h100000, 32'h080000, 32'h040000, 32'h100000,
      32'h180000, 32'h0C0000, 32'h060000, 32'h080000,
      32'h080000, 32'h040000, 32'h020000, 32'h180000,
      32'h0C0000, 32'h060000, 32'h030000, 32'h0C0000};
    logic [1:0]  ed;
    logic [31:0] ei;
    run(1'b0, 32'd4, -1, 0, -1);
    checks++; if (cap_n != 16) $display("FAIL vdc_count: got %0d want 16", cap_n); else passes++;
    for (int i = 0; i < 16; i++) begin
      ed = 2'(i % 4);
      ei = 32'(i / 4 + 1);
      checks++;
      if (cap_u[i] !== exp_u[i] || cap_dim[i] !== ed || cap_idx[i] !== ei)
        $display("FAIL vdc_sample%0d: got u=%h d=%0d i=%0d want u=%h d=%0d i=%0d",
                 i, cap_u[i], cap_dim[i], cap_idx[i], exp_u[i], ed, ei);
      else passes++;
    end
    checks++; if (busy0 !== 1'b1) $display("FAIL vdc_busy_start: got %b want 1", busy0); else passes++;
    checks++; if (first_vld != 1) $display("FAIL vdc_latency: got %0d want 1", first_vld); else passes++;
    checks++; if (last_acc != 16) $display("FAIL vdc_no_bubbles: got %0d want 16", last_acc); else passes++;
    checks++; if (done_cyc != 17) $display("FAIL vdc_done_time: got %0d want 17", done_cyc); else passes++;
    checks++; if (done_cnt != 1) $display("FAIL vdc_done_pulses: got %0d want 1", done_cnt); else passes++;
    checks++; if (timed_out) $display("FAIL vdc_timeout: got 1 want 0"); else passes++;
    checks++; if (busy_a !== 1'b0) $display("FAIL vdc_busy_end: got %b want 0", busy_a); else passes++;
  endtask

  task automatic test_dims2;
    logic [31:0] eu [4] = '{32'h100000, 32'h100000, 32'h180000, 32'h180000};
    logic [1:0]  ed [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
    logic [31:0] ei [4] = '{32'd1, 32'd1, 32'd2, 32'd2};
    run(1'b1, 32'd2, -1, 0, -1);
    checks++; if (cap_n != 4) $display("FAIL dims2_count: got %0d want 4", cap_n); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_u[i] !== eu[i] || cap_dim[i] !== ed[i] || cap_idx[i] !== ei[i])
        $display("FAIL dims2_sample%0d: got u=%h d=%0d i=%0d want u=%h d=%0d i=%0d",
                 i, cap_u[i], cap_dim[i], cap_idx[i], eu[i], ed[i], ei[i]);
      else passes++;
    end
    checks++; if (done_cnt != 1) $display("FAIL dims2_done: got %0d want 1", done_cnt); else passes++;
    sel = 1'b0;
  endtask

  task automatic test_backpressure;
    int bad;
    run(1'b0, 32'd8, -1, 0, -1);
    for (int i = 0; i < 32; i++) begin
      ref_u[i] = cap_u[i]; ref_dim[i] = cap_dim[i]; ref_idx[i] = cap_idx[i];
    end
    checks++; if (cap_n != 32) $display("FAIL bp_ref_count: got %0d want 32", cap_n); else passes++;
    checks++; if (ref_u[16] !== 32'h1C0000) $display("FAIL bp_ref_idx5: got %h want 1c0000", ref_u[16]); else passes++;
    checks++; if (ref_u[28] !== 32'h060000) $display("FAIL bp_ref_idx8: got %h want 060000", ref_u[28]); else passes++;
    run(1'b0, 32'd8, 5, 5, -1);
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (cap_u[i] !== ref_u[i] || cap_dim[i] !== ref_dim[i] || cap_idx[i] !== ref_idx[i]) bad++;
    checks++; if (cap_n != 32) $display("FAIL bp_count: got %0d want 32", cap_n); else passes++;
    checks++; if (bad != 0) $display("FAIL bp_sequence: got %0d differing samples want 0", bad); else passes++;
    checks++; if (frozen_bad) $display("FAIL bp_frozen: got outputs changed want held"); else passes++;
    checks++; if (last_acc != 37) $display("FAIL bp_last_accept: got %0d want 37", last_acc); else passes++;
    checks++; if (done_cnt != 1) $display("FAIL bp_done: got %0d want 1", done_cnt); else passes++;
  endtask

  task automatic test_clamp;
    dv_dim = 2'd0; dv_bit = 5'd0; dv_data = 32'h0000_0400; we_a = 1'b1;
    run(1'b0, 32'd1, -1, 0, -1);
    checks++; if (cap_n != 4) $display("FAIL clamp_count: got %0d want 4", cap_n); else passes++;
    checks++; if (cap_u[0] !== 32'h1) $display("FAIL clamp_u: got %h want 1", cap_u[0]); else passes++;
    checks++; if (cap_u[1] !== 32'h080000) $display("FAIL clamp_dim1: got %h want 080000", cap_u[1]); else passes++;
    checks++; if (done_cnt != 1) $display("FAIL clamp_done: got %0d want 1", done_cnt); else passes++;
    wr(1'b0, 0, 0, 32'h8000_0000);
  endtask

  task automatic test_control;
    int bad;
    n_points = 32'd0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy_a || done_a || valid_a) bad++;
    end
    checks++; if (bad != 0) $display("FAIL ctl_zero_start: got %0d active cycles want 0", bad); else passes++;
    run(1'b0, 32'd2, -1, 0, 3);
    checks++; if (cap_n != 8) $display("FAIL ctl_restart_count: got %0d want 8", cap_n); else passes++;
    checks++; if (cap_idx[7] !== 32'd2) $display("FAIL ctl_restart_idx: got %0d want 2", cap_idx[7]); else passes++;
    checks++; if (done_cnt != 1) $display("FAIL ctl_restart_done: got %0d want 1", done_cnt); else passes++;
    run(1'b0, 32'd1, -1, 0, -1);
    checks++; if (cap_u[0] !== 32'h100000) $display("FAIL ctl_ram_kept: got %h want 100000", cap_u[0]); else passes++;
  endtask

  task automatic test_reset_midrun;
    int seen, bad;
    bit hit;
    n_points = 32'd8; start_a = 1'b1; ready_in = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    seen = 0; hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (valid_a) seen++;
      if (seen == 3) begin rst_n = 1'b0; hit = 1'b1; end
    end
    checks++; if (!hit) $display("FAIL mid_reset_reach: got %0d samples want 3", seen); else passes++;
    @(negedge clk);
    checks++; if (valid_a !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", valid_a); else passes++;
    checks++; if (busy_a !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", busy_a); else passes++;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_a || valid_a) bad++;
    end
    checks++; if (bad != 0) $display("FAIL mid_reset_quiet: got %0d active cycles want 0", bad); else passes++;
    run(1'b0, 32'd8, -1, 0, -1);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (cap_u[i] !== ref_u[i] || cap_dim[i] !== ref_dim[i] || cap_idx[i] !== ref_idx[i]) bad++;
    checks++; if (bad != 0) $display("FAIL mid_reset_rerun: got %0d differing samples want 0", bad); else passes++;
    checks++; if (done_cnt != 1) $display("FAIL mid_reset_rerun_done: got %0d want 1", done_cnt); else passes++;
  endtask

  initial begin
    test_reset;
    for (int dm = 0; dm < 4; dm++)
      for (int k = 0; k < 32; k++) wr(1'b0, dm, k, vfor(dm, k));
    for (int dm = 0; dm < 2; dm++)
      for (int k = 0; k < 32; k++) wr(1'b1, dm, k, vfor(0, k));
    test_vdc;
    test_dims2;
    test_backpressure;
    test_clamp;
    test_control;
    test_reset_midrun;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
